// File: rtl/sync_fifo_param.sv
// Single-clock FIFO of any depth (not limited to powers of two) with occupancy count,
// threshold flags, flush and sticky error flags. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 10,
    parameter int AF_LEVEL = 8,
    parameter int AE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            din,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            dout,
    output logic                         dout_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              run;

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count <= CNT_W'(AE_LEVEL));

    // A pop at full frees a slot in the same edge, so a simultaneous write is still accepted.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);
    assign run    = rst_n & ~clr;

    always_ff @(posedge clk) begin
        if (run && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Error flags survive a flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!clr) begin
            if (wr_en && !wr_acc) begin
                overflow <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign dout       = empty ? '0 : mem[rd_ptr];
    assign dout_valid = ~empty;
`else
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= rd_acc;
            if (rd_acc) begin
                dout <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based reference model.
// Honours SYNC_FIFO_FWFT_EN the same way the design does.
module tb_sync_fifo_param;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 10;
    localparam int AF_LEVEL = 8;
    localparam int AE_LEVEL = 2;
    localparam int CNT_W    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n, clr, wr_en, rd_en;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              dout_valid, full, empty, almost_full, almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow, underflow;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] q[$];
    logic              m_ovf, m_udf, m_dv;
    logic [DATA_W-1:0] m_dout;

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Queue semantics: pop the head, then push; the full+write+read case falls out naturally.
    task automatic model_update();
        logic rd_ok, wr_ok;
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0; m_udf = 1'b0; m_dout = '0; m_dv = 1'b0;
        end else if (clr) begin
            q.delete();
            m_dout = '0; m_dv = 1'b0;
        end else begin
            rd_ok = rd_en && (q.size() > 0);
            wr_ok = wr_en && ((q.size() < DEPTH) || rd_ok);
            if (wr_en && !wr_ok) m_ovf = 1'b1;
            if (rd_en && q.size() == 0) m_udf = 1'b1;
            m_dv = rd_ok;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(din);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        check("count", 32'(count), 32'(n));
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("almost_full", 32'(almost_full), 32'(n >= AF_LEVEL));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE_LEVEL));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        check("dout_fwft", 32'(dout), (n > 0) ? 32'(q[0]) : 32'd0);
        check("dout_valid_fwft", 32'(dout_valid), 32'(n > 0));
`else
        check("dout", 32'(dout), 32'(m_dout));
        check("dout_valid", 32'(dout_valid), 32'(m_dv));
`endif
    endtask

    task automatic step(input logic r, input logic c, input logic w,
                        input logic [DATA_W-1:0] d, input logic rd);
        rst_n = r; clr = c; wr_en = w; din = d; rd_en = rd;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        step(1'b1, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic pop();
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        int pw, pr;
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;

        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);

        // Fill, overfill, drain, then read once more on empty.
        for (int i = 1; i <= DEPTH; i++) push(DATA_W'(i));
        push(8'hFF);
        check("ovf_sticky_set", 32'(overflow), 32'd1);
        for (int i = 0; i < DEPTH; i++) pop();
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        pop();
        check("udf_set", 32'(underflow), 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'hA7, 1'b1);
        check("empty_wr_rd_count", 32'(count), 32'd1);
        pop();

        // Wrap the pointers across the DEPTH-1 -> 0 boundary.
        for (int i = 0; i < 6; i++) push(DATA_W'(8'h20 + i));
        for (int i = 0; i < 6; i++) pop();
        for (int i = 0; i < DEPTH; i++) push(DATA_W'(8'h40 + i));
        for (int i = 0; i < DEPTH; i++) pop();

        // Simultaneous write and read while full.
        for (int i = 0; i < DEPTH; i++) push(DATA_W'(8'h60 + i));
        step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        check("full_wr_rd_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) pop();

        // Flush keeps the error flags.
        for (int i = 0; i < 5; i++) push(DATA_W'(8'h90 + i));
        step(1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
        check("clr_keeps_ovf", 32'(overflow), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Random traffic with shifting read/write bias, occasional flush and reset.
        for (int blk = 0; blk < 8; blk++) begin
            pw = $urandom_range(20, 90);
            pr = $urandom_range(20, 90);
            for (int i = 0; i < 400; i++) begin
                step(($urandom_range(0, 299) != 0),
                     ($urandom_range(0, 79) == 0),
                     ($urandom_range(0, 99) < pw),
                     DATA_W'($urandom),
                     ($urandom_range(0, 99) < pr));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
